// File: rtl/car_sprite_pipe_pkg.sv
// Shared constants and helpers for the car sprite fetch path.
// Contents:
//   - sprite geometry (75x75)
//   - sprite-sheet layout (600 px wide, two rows of eight headings, 90000 words)
//   - screen size and RGB width
//   - heading_index(): maps a 0..359 degree heading onto one of 16 sheet cells
package car_sprite_pipe_pkg;

  localparam int unsigned SPRITE_W       = 75;
  localparam int unsigned SPRITE_H       = 75;
  localparam int unsigned SHEET_W        = 600;
  localparam int unsigned SHEET_WORDS    = 90000;
  localparam int unsigned SHEET_COLS     = 8;
  localparam int unsigned SCREEN_W       = 640;
  localparam int unsigned SCREEN_H       = 480;
  localparam int unsigned RGB_W          = 12;
  localparam int unsigned ADDR_W         = 17;
  localparam logic [11:0] KEY_COLOR      = 12'h0F0;
  localparam logic [8:0]  MAX_DEGREE     = 9'd359;

  typedef logic [RGB_W-1:0]  rgb_t;
  typedef logic [ADDR_W-1:0] sheet_addr_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } car_pos_t;

  // Each sheet cell covers 22.5 degrees. Comparing 2*deg against multiples
  // of 45 keeps the whole thing integer and avoids a real divider.
  function automatic logic [3:0] heading_index(input logic [8:0] deg);
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if ({deg, 1'b0} >= 10'(45 * k)) idx = idx + 4'd1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/car_sprite_pipe_car_addr.sv
// car_addr: heading + local pixel -> sprite-sheet word address (combinational).
// Sheet layout: cells 0..7 form the top 75-row band, cells 8..15 the bottom
// band; each cell is 75 px wide, and the sheet is 600 words per row.
// Ports:
//   degree   in  9   heading, 0..359
//   pixel_x  in  7   column inside the sprite, 0..74
//   pixel_y  in  7   row inside the sprite, 0..74
//   addr     out 17  linear sheet address
module car_addr
  import car_sprite_pipe_pkg::*;
(
  input  logic [8:0]  degree,
  input  logic [6:0]  pixel_x,
  input  logic [6:0]  pixel_y,
  output logic [16:0] addr
);

  logic [3:0]  idx;
  logic [16:0] sheet_row;
  logic [16:0] sheet_col;

  // Bit 3 of the cell index selects the lower band; bits 2:0 select the cell
  // within the band.
  always_comb begin
    idx       = heading_index(degree);
    sheet_row = 17'(pixel_y) + (idx[3] ? 17'(SPRITE_H) : 17'd0);
    sheet_col = 17'(idx[2:0]) * 17'(SPRITE_W) + 17'(pixel_x);
    addr      = sheet_row * 17'(SHEET_W) + sheet_col;
  end

endmodule

// File: rtl/car_sprite_pipe.sv
// car_sprite_pipe: per-pixel car sprite fetch between scan counters and mixer.
// Latches car position/heading on frame_start, tests each scan point against
// the 75x75 car box, addresses the sprite-sheet BRAM and returns the colour
// plus an opaque-hit flag exactly 3 cycles after the scan sample.
// Ports:
//   clk, rst            pixel clock, async active-high reset
//   h_cnt, v_cnt, valid scan point and active-video enable
//   frame_start         one-cycle pulse at start of vertical blank
//   car_x, car_y        requested sprite top-left
//   degree_in           requested heading, 0..359 (larger values ignored)
//   rom_addr, rom_data  sprite-sheet BRAM port (1-cycle read latency)
//   car_rgb, car_hit    aligned colour and opaque flag
module car_sprite_pipe
  import car_sprite_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        frame_start,
  input  logic [9:0]  car_x,
  input  logic [9:0]  car_y,
  input  logic [8:0]  degree_in,
  output logic [16:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] car_rgb,
  output logic        car_hit
);

  car_pos_t    pos_q;
  logic [8:0]  deg_q;
  logic        in_box;
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic [6:0]  px_c;
  logic [6:0]  py_c;
  logic [16:0] addr_c;
  logic        box_v;
  logic        box_v_d;
  logic        hit_c;

  // Frame latch: position and heading only change on the frame_start cycle,
  // so a scan point sampled in that same cycle still sees the old values.
  // Out-of-range headings are dropped rather than clamped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      deg_q <= '0;
    end else if (frame_start) begin
      pos_q <= '{x: car_x, y: car_y};
      if (degree_in <= MAX_DEGREE) deg_q <= degree_in;
    end
  end

  // Box test with 11-bit end coordinates so a car near the right or bottom
  // edge clips instead of wrapping back onto column/row 0.
  // The local offsets are below 75 whenever in_box holds, so the low 7 bits
  // of the subtraction are already exact.
  always_comb begin
    x_end  = {1'b0, pos_q.x} + 11'(SPRITE_W);
    y_end  = {1'b0, pos_q.y} + 11'(SPRITE_H);
    in_box = valid &&
             (h_cnt >= pos_q.x) && ({1'b0, h_cnt} < x_end) &&
             (v_cnt >= pos_q.y) && ({1'b0, v_cnt} < y_end);
    px_c   = 7'd0;
    py_c   = 7'd0;
    if (in_box) begin
      px_c = h_cnt[6:0] - pos_q.x[6:0];
      py_c = v_cnt[6:0] - pos_q.y[6:0];
    end
  end

  car_addr u_car_addr (
    .degree  (deg_q),
    .pixel_x (px_c),
    .pixel_y (py_c),
    .addr    (addr_c)
  );

  // Stage 1 registers the BRAM address and the in-box flag; stage 2 delays
  // the flag so it lines up with the BRAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      box_v    <= 1'b0;
      box_v_d  <= 1'b0;
    end else begin
      rom_addr <= addr_c;
      box_v    <= in_box;
      box_v_d  <= box_v;
    end
  end

  // Stage 3: key-coloured texels are transparent, and anything outside the
  // box reports black with no hit regardless of what the BRAM returned.
  always_comb begin
    hit_c = box_v_d && (rom_data != KEY_COLOR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_hit <= 1'b0;
      car_rgb <= '0;
    end else begin
      car_hit <= hit_c;
      car_rgb <= hit_c ? rom_data : 12'h000;
    end
  end

endmodule

// File: tb/tb_car_sprite_pipe.sv
// Directed bench for car_sprite_pipe with a synchronous BRAM model.
module tb_car_sprite_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic        frame_start;
  logic [9:0]  car_x;
  logic [9:0]  car_y;
  logic [8:0]  degree_in;
  logic [16:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] car_rgb;
  logic        car_hit;

  int n_cmp = 0;
  int n_bad = 0;

  logic        bram_const_mode = 1'b0;
  logic [11:0] bram_const      = 12'h000;

  always #5 clk = ~clk;

  car_sprite_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid       (valid),
    .frame_start (frame_start),
    .car_x       (car_x),
    .car_y       (car_y),
    .degree_in   (degree_in),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .car_rgb     (car_rgb),
    .car_hit     (car_hit)
  );

  // Sheet contents: a fixed scramble of the address, or a forced constant.
  function automatic logic [11:0] sheet_word(input logic [16:0] a);
    return a[11:0] ^ 12'hA5A;
  endfunction

  always @(posedge clk) begin
    rom_data <= bram_const_mode ? bram_const : sheet_word(rom_addr);
  end

  // Stimulus helpers: all inputs change 1 time unit after a rising edge.
  task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic [8:0] d);
    frame_start = 1'b1; car_x = x; car_y = y; degree_in = d;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic scan(input logic [9:0] h, input logic [9:0] v,
                      output logic [16:0] addr1, output logic hit3, output logic [11:0] rgb3);
    h_cnt = h; v_cnt = v; valid = 1'b1;
    @(posedge clk); #1;
    addr1 = rom_addr;
    valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    hit3 = car_hit;
    rgb3 = car_rgb;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; frame_start = 1'b0;
    h_cnt = '0; v_cnt = '0; car_x = '0; car_y = '0; degree_in = '0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (rom_addr !== 17'd0) begin n_bad++; $display("[TB] FAIL reset_addr got %0d want 0", rom_addr); end
    n_cmp++; if (car_hit !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_hit got %b want 0", car_hit); end
    n_cmp++; if (car_rgb !== 12'h000) begin n_bad++; $display("[TB] FAIL reset_rgb got %h want 000", car_rgb); end
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (car_hit !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_hit got %b want 0", car_hit); end
  endtask

  task automatic test_basic_hit();
    logic [16:0] a; logic h; logic [11:0] c;
    frame(10'd100, 10'd50, 9'd0);
    scan(10'd100, 10'd50, a, h, c);
    n_cmp++; if (a !== 17'd0) begin n_bad++; $display("[TB] FAIL t1_addr got %0d want 0", a); end
    n_cmp++; if (h !== 1'b1) begin n_bad++; $display("[TB] FAIL t1_hit got %b want 1", h); end
    n_cmp++; if (c !== 12'hA5A) begin n_bad++; $display("[TB] FAIL t1_rgb got %h want a5a", c); end
  endtask

  task automatic test_box_edges();
    logic [16:0] a; logic h; logic [11:0] c;
    scan(10'd174, 10'd124, a, h, c);
    n_cmp++; if (a !== 17'd44474) begin n_bad++; $display("[TB] FAIL t2_corner_addr got %0d want 44474", a); end
    n_cmp++; if (h !== 1'b1) begin n_bad++; $display("[TB] FAIL t2_corner_hit got %b want 1", h); end
    n_cmp++; if (c !== sheet_word(17'd44474)) begin n_bad++; $display("[TB] FAIL t2_corner_rgb got %h want %h", c, sheet_word(17'd44474)); end
    scan(10'd175, 10'd124, a, h, c);
    n_cmp++; if (h !== 1'b0) begin n_bad++; $display("[TB] FAIL t2_right_hit got %b want 0", h); end
    n_cmp++; if (c !== 12'h000) begin n_bad++; $display("[TB] FAIL t2_right_rgb got %h want 000", c); end
    n_cmp++; if (a !== 17'd0) begin n_bad++; $display("[TB] FAIL t2_right_addr got %0d want 0", a); end
    scan(10'd100, 10'd125, a, h, c);
    n_cmp++; if (h !== 1'b0) begin n_bad++; $display("[TB] FAIL t2_below_hit got %b want 0", h); end
    scan(10'd99, 10'd60, a, h, c);
    n_cmp++; if (h !== 1'b0) begin n_bad++; $display("[TB] FAIL t2_left_hit got %b want 0", h); end
    scan(10'd110, 10'd49, a, h, c);
    n_cmp++; if (h !== 1'b0) begin n_bad++; $display("[TB] FAIL t2_above_hit got %b want 0", h); end
  endtask

  task automatic test_heading();
    logic [16:0] a; logic h; logic [11:0] c;
    frame(10'd0, 10'd0, 9'd200);
    scan(10'd0, 10'd0, a, h, c);
    n_cmp++; if (a !== 17'd45000) begin n_bad++; $display("[TB] FAIL t3_deg200_addr got %0d want 45000", a); end
    frame(10'd0, 10'd0, 9'd100);
    scan(10'd0, 10'd0, a, h, c);
    n_cmp++; if (a !== 17'd300) begin n_bad++; $display("[TB] FAIL t3_deg100_addr got %0d want 300", a); end
    frame(10'd0, 10'd0, 9'd359);
    scan(10'd0, 10'd0, a, h, c);
    n_cmp++; if (a !== 17'd45525) begin n_bad++; $display("[TB] FAIL t3_deg359_addr got %0d want 45525", a); end
  endtask

  task automatic test_key_color();
    logic [16:0] a; logic h; logic [11:0] c;
    frame(10'd0, 10'd0, 9'd0);
    bram_const_mode = 1'b1;
    bram_const = 12'h0F0;
    scan(10'd10, 10'd10, a, h, c);
    n_cmp++; if (a !== 17'd6010) begin n_bad++; $display("[TB] FAIL t4_addr got %0d want 6010", a); end
    n_cmp++; if (h !== 1'b0) begin n_bad++; $display("[TB] FAIL t4_key_hit got %b want 0", h); end
    n_cmp++; if (c !== 12'h000) begin n_bad++; $display("[TB] FAIL t4_key_rgb got %h want 000", c); end
    bram_const = 12'hF00;
    scan(10'd10, 10'd10, a, h, c);
    n_cmp++; if (h !== 1'b1) begin n_bad++; $display("[TB] FAIL t4_red_hit got %b want 1", h); end
    n_cmp++; if (c !== 12'hF00) begin n_bad++; $display("[TB] FAIL t4_red_rgb got %h want f00", c); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (car_hit !== 1'b0) begin n_bad++; $display("[TB] FAIL t4_invalid_hit got %b want 0", car_hit); end
    bram_const_mode = 1'b0;
  endtask

  task automatic test_clip();
    logic [16:0] a; logic h; logic [11:0] c;
    frame(10'd600, 10'd0, 9'd0);
    scan(10'd639, 10'd0, a, h, c);
    n_cmp++; if (a !== 17'd39) begin n_bad++; $display("[TB] FAIL clip_addr got %0d want 39", a); end
    n_cmp++; if (h !== 1'b1) begin n_bad++; $display("[TB] FAIL clip_hit got %b want 1", h); end
    frame(10'd0, 10'd450, 9'd0);
    scan(10'd20, 10'd479, a, h, c);
    n_cmp++; if (a !== 17'd17420) begin n_bad++; $display("[TB] FAIL clip_v_addr got %0d want 17420", a); end
  endtask

  task automatic test_frame_latch();
    logic [16:0] a; logic h; logic [11:0] c;
    frame(10'd0, 10'd0, 9'd100);
    frame(10'd100, 10'd50, 9'd400);
    scan(10'd100, 10'd50, a, h, c);
    n_cmp++; if (a !== 17'd300) begin n_bad++; $display("[TB] FAIL t5_deg_hold_addr got %0d want 300", a); end
    // frame_start coincides with an in-box scan at the old position
    frame_start = 1'b1; car_x = 10'd300; car_y = 10'd300; degree_in = 9'd0;
    h_cnt = 10'd101; v_cnt = 10'd51; valid = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    valid = 1'b0;
    a = rom_addr;
    n_cmp++; if (a !== 17'd901) begin n_bad++; $display("[TB] FAIL t5_same_cycle_addr got %0d want 901", a); end
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (car_hit !== 1'b1) begin n_bad++; $display("[TB] FAIL t5_same_cycle_hit got %b want 1", car_hit); end
    n_cmp++; if (car_rgb !== sheet_word(17'd901)) begin n_bad++; $display("[TB] FAIL t5_same_cycle_rgb got %h want %h", car_rgb, sheet_word(17'd901)); end
    scan(10'd101, 10'd51, a, h, c);
    n_cmp++; if (h !== 1'b0) begin n_bad++; $display("[TB] FAIL t5_new_pos_hit got %b want 0", h); end
    scan(10'd301, 10'd302, a, h, c);
    n_cmp++; if (a !== 17'd1201) begin n_bad++; $display("[TB] FAIL t5_new_pos_addr got %0d want 1201", a); end
  endtask

  task automatic test_reset_mid_frame();
    logic [16:0] a; logic h; logic [11:0] c;
    frame(10'd200, 10'd100, 9'd200);
    h_cnt = 10'd200; v_cnt = 10'd100; valid = 1'b1;
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (car_hit !== 1'b1) begin n_bad++; $display("[TB] FAIL t6_pre_hit got %b want 1", car_hit); end
    n_cmp++; if (rom_addr !== 17'd45000) begin n_bad++; $display("[TB] FAIL t6_pre_addr got %0d want 45000", rom_addr); end
    rst = 1'b1;
    #1;
    n_cmp++; if (car_hit !== 1'b0) begin n_bad++; $display("[TB] FAIL t6_async_hit got %b want 0", car_hit); end
    n_cmp++; if (car_rgb !== 12'h000) begin n_bad++; $display("[TB] FAIL t6_async_rgb got %h want 000", car_rgb); end
    n_cmp++; if (rom_addr !== 17'd0) begin n_bad++; $display("[TB] FAIL t6_async_addr got %0d want 0", rom_addr); end
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    scan(10'd200, 10'd100, a, h, c);
    n_cmp++; if (h !== 1'b0) begin n_bad++; $display("[TB] FAIL t6_old_pos_hit got %b want 0", h); end
    scan(10'd5, 10'd5, a, h, c);
    n_cmp++; if (a !== 17'd3005) begin n_bad++; $display("[TB] FAIL t6_default_addr got %0d want 3005", a); end
    n_cmp++; if (h !== 1'b1) begin n_bad++; $display("[TB] FAIL t6_default_hit got %b want 1", h); end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_box_edges();
    test_heading();
    test_key_color();
    test_clip();
    test_frame_latch();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
